excp_ctrl: RTL and testbench

EXCP_CTRL -- requirements
Module: excp_ctrl

---
 rtl/excp_ctrl.sv | 147 ++++++++++++++
 tb/tb_excp_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/excp_ctrl.sv
// Writeback exception/ERTN controller: accepts one event, strobes the CSR file
// for one cycle, then holds a redirect until fetch accepts it. Macro: EXCP_INT_EN.
module excp_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [4:0]  wb_ex_flags,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        redirect_ready,
    output logic        wb_allowin,
    output logic        csr_wb_ex,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_pc,
    output logic [31:0] csr_vaddr,
    output logic        csr_ertn_flush,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, COMMIT, REDIR} state_t;

    state_t      state_q, state_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esubcode_q, esubcode_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] target_q, target_d;
    logic        wb_ex_q, wb_ex_d;
    logic        ertn_q, ertn_d;
    logic        flush_q, flush_d;
    logic        redir_q, redir_d;
    logic        busy_q, busy_d;
    logic        allowin_q, allowin_d;

    logic        int_ev;
    logic        exc_ev;
    logic        accept;
    logic [5:0]  ecode_sel;

`ifdef EXCP_INT_EN
    assign int_ev = has_int;
`else
    logic unused_has_int;
    assign unused_has_int = has_int;
    assign int_ev         = 1'b0;
`endif

    assign exc_ev = int_ev | (|wb_ex_flags);
    assign accept = (state_q == IDLE) && wb_valid && (exc_ev || wb_ertn);

    // Fixed priority: INT, ADEF, INE, SYS, BRK, ALE.
    always_comb begin
        ecode_sel = 6'h09;
        if (int_ev)              ecode_sel = 6'h00;
        else if (wb_ex_flags[0]) ecode_sel = 6'h08;
        else if (wb_ex_flags[1]) ecode_sel = 6'h0D;
        else if (wb_ex_flags[2]) ecode_sel = 6'h0B;
        else if (wb_ex_flags[3]) ecode_sel = 6'h0C;
    end

    always_comb begin
        state_d    = state_q;
        ecode_d    = ecode_q;
        esubcode_d = esubcode_q;
        pc_d       = pc_q;
        vaddr_d    = vaddr_q;
        target_d   = target_q;
        wb_ex_d    = 1'b0;
        ertn_d     = 1'b0;
        flush_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COMMIT;
                    flush_d = 1'b1;
                    // An exception always wins over a simultaneous ERTN.
                    if (exc_ev) begin
                        wb_ex_d    = 1'b1;
                        ecode_d    = ecode_sel;
                        esubcode_d = 9'd0;
                        pc_d       = wb_pc;
                        vaddr_d    = wb_vaddr;
                        target_d   = csr_eentry;
                    end else begin
                        ertn_d   = 1'b1;
                        target_d = csr_era;
                    end
                end
            end
            COMMIT:  state_d = REDIR;
            REDIR:   if (redirect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        redir_d   = (state_d == REDIR);
        busy_d    = (state_d != IDLE);
        allowin_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ecode_q    <= 6'd0;
            esubcode_q <= 9'd0;
            pc_q       <= 32'd0;
            vaddr_q    <= 32'd0;
            target_q   <= 32'd0;
            wb_ex_q    <= 1'b0;
            ertn_q     <= 1'b0;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            busy_q     <= 1'b0;
            allowin_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            ecode_q    <= ecode_d;
            esubcode_q <= esubcode_d;
            pc_q       <= pc_d;
            vaddr_q    <= vaddr_d;
            target_q   <= target_d;
            wb_ex_q    <= wb_ex_d;
            ertn_q     <= ertn_d;
            flush_q    <= flush_d;
            redir_q    <= redir_d;
            busy_q     <= busy_d;
            allowin_q  <= allowin_d;
        end
    end

    assign wb_allowin     = allowin_q;
    assign csr_wb_ex      = wb_ex_q;
    assign csr_ertn_flush = ertn_q;
    assign pipe_flush     = flush_q;
    assign csr_ecode      = ecode_q;
    assign csr_esubcode   = esubcode_q;
    assign csr_pc         = pc_q;
    assign csr_vaddr      = vaddr_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = target_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_excp_ctrl.sv
// Bench for excp_ctrl: directed vectors plus a cycle-count model of the
// accept -> commit -> redirect sequence checked on every falling edge.
module tb_excp_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_vaddr = '0;
    logic [4:0]  wb_ex_flags = '0;
    logic        wb_ertn = 1'b0;
    logic        has_int = 1'b0;
    logic [31:0] csr_eentry = '0;
    logic [31:0] csr_era = '0;
    logic        redirect_ready = 1'b0;
    logic        wb_allowin, csr_wb_ex, csr_ertn_flush, pipe_flush, redirect_valid, busy;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_pc, csr_vaddr, redirect_pc;

    int checks = 0;
    int errors = 0;

    excp_ctrl dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .wb_ex_flags(wb_ex_flags), .wb_ertn(wb_ertn),
        .has_int(has_int), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .redirect_ready(redirect_ready), .wb_allowin(wb_allowin),
        .csr_wb_ex(csr_wb_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_pc(csr_pc), .csr_vaddr(csr_vaddr), .csr_ertn_flush(csr_ertn_flush),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0; wb_ex_flags = '0; wb_ertn = 1'b0; has_int = 1'b0;
    endtask

    // Lowest flag index is the highest-priority cause.
    function automatic logic [5:0] cause(input logic [4:0] f);
        logic [5:0] tbl [0:4];
        tbl[0] = 6'h08; tbl[1] = 6'h0D; tbl[2] = 6'h0B; tbl[3] = 6'h0C; tbl[4] = 6'h09;
        cause = 6'h00;
        for (int i = 4; i >= 0; i--) if (f[i]) cause = tbl[i];
    endfunction

    // m_since: 0 = idle, 1 = commit cycle, >=2 = cycles spent waiting on redirect.
    int          m_since;
    logic        m_is_exc;
    logic [5:0]  m_ec;
    logic [31:0] m_pc, m_va, m_tgt;

    always @(posedge clk or negedge resetn) begin
        logic int_on;
        if (!resetn) begin
            m_since = 0; m_is_exc = 0; m_ec = 0; m_pc = 0; m_va = 0; m_tgt = 0;
        end else if (m_since == 0) begin
`ifdef EXCP_INT_EN
            int_on = has_int;
`else
            int_on = 1'b0;
`endif
            if (wb_valid && (int_on || wb_ex_flags != 0 || wb_ertn)) begin
                m_since  = 1;
                m_is_exc = int_on || (wb_ex_flags != 0);
                if (m_is_exc) begin
                    m_ec  = int_on ? 6'h00 : cause(wb_ex_flags);
                    m_pc  = wb_pc;
                    m_va  = wb_vaddr;
                    m_tgt = csr_eentry;
                end else begin
                    m_tgt = csr_era;
                end
            end
        end else if (m_since == 1) begin
            m_since = 2;
        end else if (redirect_ready) begin
            m_since = 0;
        end else begin
            m_since++;
        end
    end

    always @(negedge clk) begin
        chk("m_allowin",  wb_allowin,     m_since == 0);
        chk("m_busy",     busy,           m_since != 0);
        chk("m_wb_ex",    csr_wb_ex,      m_since == 1 && m_is_exc);
        chk("m_ertn",     csr_ertn_flush, m_since == 1 && !m_is_exc);
        chk("m_flush",    pipe_flush,     m_since == 1);
        chk("m_redir",    redirect_valid, m_since >= 2);
        if (m_since >= 2) chk("m_redir_pc", redirect_pc, m_tgt);
        chk("m_ecode",    csr_ecode,      m_ec);
        chk("m_esub",     csr_esubcode,   0);
        chk("m_pc",       csr_pc,         m_pc);
        chk("m_vaddr",    csr_vaddr,      m_va);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_allowin", wb_allowin, 1);
        chk("rst_busy", busy, 0);
        chk("rst_redir", redirect_valid, 0);
        chk("rst_pc", csr_pc, 0);

        // ADEF, presented as reset releases: accepted on the first edge.
        wb_valid = 1; wb_ex_flags = 5'b00001; wb_pc = 32'h1C000100;
        wb_vaddr = 32'h0000_0ABC; csr_eentry = 32'h1C008000;
        resetn = 1;
        step();
        chk("adef_wb_ex", csr_wb_ex, 1);
        chk("adef_flush", pipe_flush, 1);
        chk("adef_ecode", csr_ecode, 6'h08);
        chk("adef_sub", csr_esubcode, 0);
        chk("adef_pc", csr_pc, 32'h1C000100);
        chk("adef_allowin", wb_allowin, 0);
        clear_wb();
        step();
        chk("adef_wb_ex_once", csr_wb_ex, 0);
        chk("adef_redir", redirect_valid, 1);
        chk("adef_redir_pc", redirect_pc, 32'h1C008000);
        redirect_ready = 1;
        step();
        chk("adef_idle", busy, 0);
        redirect_ready = 0;

        // Exception beats a simultaneous ERTN.
        wb_valid = 1; wb_ex_flags = 5'b11110; wb_ertn = 1; wb_pc = 32'h1C000200;
        step();
        chk("prio_ecode", csr_ecode, 6'h0D);
        chk("prio_ertn", csr_ertn_flush, 0);
        chk("prio_wb_ex", csr_wb_ex, 1);
        clear_wb();
        step();
        redirect_ready = 1;
        step();
        redirect_ready = 0;

        // ERTN with a slow fetch.
        wb_valid = 1; wb_ertn = 1; csr_era = 32'h1C000204;
        step();
        chk("ertn_flush", csr_ertn_flush, 1);
        chk("ertn_wb_ex", csr_wb_ex, 0);
        clear_wb();
        csr_era = 32'h0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("ertn_redir", redirect_valid, 1);
            chk("ertn_redir_pc", redirect_pc, 32'h1C000204);
            chk("ertn_allowin", wb_allowin, 0);
            chk("ertn_strobe_once", csr_ertn_flush, 0);
            step();
        end
        redirect_ready = 1;
        step();
        chk("ertn_idle", busy, 0);
        chk("ertn_allowin_back", wb_allowin, 1);
        redirect_ready = 0;

        // Interrupt alongside ALE; ready during commit must be ignored.
        wb_valid = 1; has_int = 1; wb_ex_flags = 5'b10000;
        wb_pc = 32'h1C000300; wb_vaddr = 32'h1C0011F3;
        step();
`ifdef EXCP_INT_EN
        chk("int_ecode", csr_ecode, 6'h00);
`else
        chk("ale_ecode", csr_ecode, 6'h09);
`endif
        chk("int_vaddr", csr_vaddr, 32'h1C0011F3);
        chk("int_wb_ex", csr_wb_ex, 1);
        clear_wb();
        redirect_ready = 1;
        step();
        chk("commit_ready_ignored", redirect_valid, 1);
        step();
        chk("int_idle", busy, 0);
        redirect_ready = 0;

        // Back-to-back SYS events with wb held valid: one accept every 3 cycles.
        wb_valid = 1; wb_ex_flags = 5'b00100; wb_pc = 32'h1C000400; redirect_ready = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("b2b_wb_ex", csr_wb_ex, (i % 3) == 0);
            chk("b2b_allowin", wb_allowin, (i % 3) == 2);
        end
        chk("b2b_ecode", csr_ecode, 6'h0B);
        clear_wb();
        redirect_ready = 0;

        // Idle noise: no valid, so nothing may be accepted.
        wb_ex_flags = 5'b11111; has_int = 1; wb_ertn = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("noise_strobe", {csr_wb_ex, csr_ertn_flush, pipe_flush}, 0);
            chk("noise_busy", busy, 0);
        end
        clear_wb();

        // Reset while redirecting.
        wb_valid = 1; wb_ex_flags = 5'b00001; wb_pc = 32'h1C000500; csr_eentry = 32'h1C008000;
        step();
        clear_wb();
        step();
        chk("pre_rst_redir", redirect_valid, 1);
        #2;
        resetn = 0;
        #1;
        chk("rst_redir_drop", redirect_valid, 0);
        chk("rst_busy_drop", busy, 0);
        chk("rst_allowin_up", wb_allowin, 1);
        chk("rst_pc_clear", csr_pc, 0);
        chk("rst_target_clear", redirect_pc, 0);
        step();
        resetn = 1;
        step();
        chk("post_rst_redir", redirect_valid, 0);
        chk("post_rst_busy", busy, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
